// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : imem_dmem_arbiter
// Shares one single-ported, fixed-latency RAM between the IF and DM ports,
// using round-robin on conflict and returning tagged read data to its owner.
// Rev    : 1.0  initial release
// ============================================================================
module imem_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iIfReq,
  input  logic [ADDR_W-1:0] iIfAddr,
  input  logic              iIfFlush,
  output logic              oIfGnt,
  output logic              oIfRdValid,
  output logic [DATA_W-1:0] oIfRdData,
  input  logic              iDmReq,
  input  logic              iDmWr,
  input  logic [ADDR_W-1:0] iDmAddr,
  input  logic [DATA_W-1:0] iDmWrData,
  output logic              oDmGnt,
  output logic              oDmRdValid,
  output logic [DATA_W-1:0] oDmRdData,
  output logic              oMemEn,
  output logic              oMemWr,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWrData,
  input  logic [DATA_W-1:0] iMemRdData
);

  localparam logic c_OWN_IF = 1'b0;
  localparam logic c_OWN_DM = 1'b1;

  logic              r_last_gnt;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_own;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_if_win;
  logic w_dm_win;

  // Eligibility is gated by resetn so every output reads zero while in reset.
  always_comb begin
    w_if_elig = resetn & iIfReq & ~iIfFlush;
    w_dm_elig = resetn & iDmReq;
    w_if_win  = w_if_elig & (~w_dm_elig | (r_last_gnt == c_OWN_DM));
    w_dm_win  = w_dm_elig & ~w_if_win;
  end

  always_comb begin
    oIfGnt     = w_if_win;
    oDmGnt     = w_dm_win;
    oMemEn     = w_if_win | w_dm_win;
    oMemWr     = w_dm_win & iDmWr;
    oMemAddr   = '0;
    oMemWrData = '0;
    if (w_if_win) begin
      oMemAddr = iIfAddr;
    end else if (w_dm_win) begin
      oMemAddr   = iDmAddr;
      oMemWrData = iDmWrData;
    end
  end

  always_comb begin
    oIfRdValid = r_tag_vld[RD_LAT-1] & (r_tag_own[RD_LAT-1] == c_OWN_IF);
    oDmRdValid = r_tag_vld[RD_LAT-1] & (r_tag_own[RD_LAT-1] == c_OWN_DM);
    oIfRdData  = resetn ? iMemRdData : '0;
    oDmRdData  = resetn ? iMemRdData : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_gnt <= c_OWN_DM;
      r_tag_vld  <= '0;
      r_tag_own  <= '0;
    end else begin
      if (w_if_win | w_dm_win) begin
        r_last_gnt <= w_dm_win ? c_OWN_DM : c_OWN_IF;
      end
      r_tag_vld[0] <= w_if_win | (w_dm_win & ~iDmWr);
      r_tag_own[0] <= w_dm_win ? c_OWN_DM : c_OWN_IF;
      // A flush kills IF-owned entries as they shift; the tail already on the
      // outputs this cycle is unaffected.
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1] & ~(iIfFlush & (r_tag_own[i-1] == c_OWN_IF));
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_dmem_arbiter
// Directed plus random stimulus against a response-queue reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_imem_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic resetn;
  logic iIfReq, iIfFlush, iDmReq, iDmWr;
  logic [ADDR_W-1:0] iIfAddr, iDmAddr;
  logic [DATA_W-1:0] iDmWrData;
  logic oIfGnt, oIfRdValid, oDmGnt, oDmRdValid, oMemEn, oMemWr;
  logic [DATA_W-1:0] oIfRdData, oDmRdData, oMemWrData, iMemRdData;
  logic [ADDR_W-1:0] oMemAddr;

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .iIfReq(iIfReq), .iIfAddr(iIfAddr), .iIfFlush(iIfFlush), .oIfGnt(oIfGnt),
    .oIfRdValid(oIfRdValid), .oIfRdData(oIfRdData),
    .iDmReq(iDmReq), .iDmWr(iDmWr), .iDmAddr(iDmAddr), .iDmWrData(iDmWrData),
    .oDmGnt(oDmGnt), .oDmRdValid(oDmRdValid), .oDmRdData(oDmRdData),
    .oMemEn(oMemEn), .oMemWr(oMemWr), .oMemAddr(oMemAddr), .oMemWrData(oMemWrData),
    .iMemRdData(iMemRdData)
  );

  always #5 clk = ~clk;

  // Environment RAM with RD_LAT-cycle read pipeline
  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  assign iMemRdData = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (oMemEn && oMemWr) mem[oMemAddr[7:0]] <= oMemWrData;
    rd_pipe[0] <= (oMemEn && !oMemWr) ? mem[oMemAddr[7:0]] : 32'h0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model: expected responses keyed by the cycle they appear
  typedef struct {
    int          due;
    bit          dm;
    logic [31:0] data;
  } resp_t;
  resp_t       q[$];
  logic [31:0] ref_mem [0:255];
  bit          last_dm;
  int          cyc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    iIfReq = 1'b1; iDmReq = 1'b1; iIfFlush = 1'b0; iDmWr = 1'b0;
    iIfAddr = 32'h10; iDmAddr = 32'h20; iDmWrData = 32'h0;
    #1;
    chk("rst_ifgnt", oIfGnt, 0);
    chk("rst_dmgnt", oDmGnt, 0);
    chk("rst_memen", oMemEn, 0);
    chk("rst_memwr", oMemWr, 0);
    chk("rst_memaddr", oMemAddr, 0);
    chk("rst_memwd", oMemWrData, 0);
    chk("rst_ifvld", oIfRdValid, 0);
    chk("rst_dmvld", oDmRdValid, 0);
    chk("rst_ifdata", oIfRdData, 0);
    chk("rst_dmdata", oDmRdData, 0);
    q.delete();
    last_dm = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;
    cyc++;
  endtask

  task automatic do_cycle(input bit ifreq, input logic [31:0] ifaddr, input bit flush,
                          input bit dmreq, input bit dmwr, input logic [31:0] dmaddr,
                          input logic [31:0] dmwd);
    bit eif, edm, gif, gdm, vif, vdm;
    logic [31:0] vdata, eaddr;
    resp_t keep[$];
    iIfReq = ifreq; iIfAddr = ifaddr; iIfFlush = flush;
    iDmReq = dmreq; iDmWr = dmwr; iDmAddr = dmaddr; iDmWrData = dmwd;
    #2;
    eif = ifreq && !flush;
    edm = dmreq;
    gif = eif && (!edm || last_dm);
    gdm = edm && !gif;
    eaddr = gif ? ifaddr : (gdm ? dmaddr : 32'h0);
    chk("ifgnt", oIfGnt, gif);
    chk("dmgnt", oDmGnt, gdm);
    chk("memen", oMemEn, gif | gdm);
    chk("memwr", oMemWr, gdm & dmwr);
    chk("memaddr", oMemAddr, eaddr);
    chk("memwd", oMemWrData, gdm ? dmwd : 32'h0);
    vif = 0; vdm = 0; vdata = 32'h0;
    foreach (q[k]) if (q[k].due == cyc) begin
      if (q[k].dm) vdm = 1; else vif = 1;
      vdata = q[k].data;
    end
    chk("ifvld", oIfRdValid, vif);
    chk("dmvld", oDmRdValid, vdm);
    if (vif) chk("ifdata", oIfRdData, vdata);
    if (vdm) chk("dmdata", oDmRdData, vdata);
    // Update model for this edge
    foreach (q[k]) if (q[k].due > cyc && !(flush && !q[k].dm)) keep.push_back(q[k]);
    q = keep;
    if (gif) q.push_back('{cyc + RD_LAT, 1'b0, ref_mem[ifaddr[7:0]]});
    if (gdm && !dmwr) q.push_back('{cyc + RD_LAT, 1'b1, ref_mem[dmaddr[7:0]]});
    if (gdm && dmwr) ref_mem[dmaddr[7:0]] = dmwd;
    if (gif || gdm) last_dm = gdm;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'h0;

    // Reset, then first contended cycle goes to IF
    reset_pulse();
    do_cycle(1, 32'h10, 0, 1, 0, 32'h20, 0);
    idle(3);

    // Single IF read
    do_cycle(1, 32'h10, 0, 0, 0, 0, 0);
    idle(3);

    // Contention for 6 cycles
    for (int i = 0; i < 6; i++) do_cycle(1, 32'h10 + i, 0, 1, 0, 32'h80 + i, 0);
    idle(3);

    // DM write then read of same address
    do_cycle(0, 0, 0, 1, 1, 32'h40, 32'h1234);
    do_cycle(0, 0, 0, 1, 0, 32'h40, 0);
    idle(3);

    // Flush: two IF reads then flush with IF and DM requesting
    do_cycle(1, 32'h20, 0, 0, 0, 0, 0);
    do_cycle(1, 32'h24, 0, 0, 0, 0, 0);
    do_cycle(1, 32'h28, 1, 1, 0, 32'h30, 0);
    idle(4);

    // Reset mid-read
    do_cycle(0, 0, 0, 1, 0, 32'h50, 0);
    reset_pulse();
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom % 4) != 0, $urandom_range(0, 255), ($urandom % 10) == 0,
               ($urandom % 3) != 0, ($urandom % 3) == 0, $urandom_range(0, 255), $urandom);
      if (($urandom % 100) == 0) reset_pulse();
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Arbitrates a single-ported, fixed-latency unified memory between the CPU instruction-fetch port (IF) and the data-memory port (DM, MEM stage). It replaces the separate instruction and data arrays with one shared RAM. Each cycle it issues at most one memory access, using round-robin order on conflict. It tags each outstanding read so the response returns to the port that issued it. It also supports flushing in-flight fetches when a branch is taken.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 2, memory read latency in cycles (legal range 1..4)

- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- iIfReq  in  1  IF read request
- iIfAddr  in  ADDR_W  IF read address
- iIfFlush  in  1  kills in-flight IF reads and blocks IF grant this cycle (branch taken)
- oIfGnt  out  1  IF request accepted this cycle
- oIfRdValid  out  1  IF read data valid
- oIfRdData  out  DATA_W  IF read data
- iDmReq  in  1  DM request
- iDmWr  in  1  1 = write, 0 = read
- iDmAddr  in  ADDR_W  DM address
- iDmWrData  in  DATA_W  DM write data
- oDmGnt  out  1  DM request accepted this cycle
- oDmRdValid  out  1  DM read data valid
- oDmRdData  out  DATA_W  DM read data
- oMemEn  out  1  memory access strobe
- oMemWr  out  1  memory write enable
- oMemAddr  out  ADDR_W  memory address
- oMemWrData  out  DATA_W  memory write data
- iMemRdData  in  DATA_W  memory read data, valid RD_LAT cycles after the oMemEn read cycle

## Operation
- **Request handshake.** A requester holds req, address and write data stable until it samples gnt=1 at a rising edge. The request completes on that edge.
- **Grant logic.** gnt is combinational from the req inputs and the rLastGnt register.
  - Only one eligible request: it is granted.
  - Both requests eligible: the port not named by rLastGnt wins.
  - rLastGnt updates on every edge on which a grant occurs.
- **Flush.** IF is eligible only when iIfReq=1 and iIfFlush=0.
- **Memory side.** The memory outputs are driven combinationally from the winner.
  - oMemEn = oIfGnt | oDmGnt.
  - oMemWr = oDmGnt & iDmWr.
  - oMemAddr and oMemWrData are muxed from the winner. oMemWrData is 0 when IF wins.
- **Tag pipeline.** A shift register of depth RD_LAT holds a {valid, owner} entry per stage.
  - Stage 0 is loaded on each edge with {read granted, owner}.
  - A DM write loads valid=0.
  - The tail entry drives oIfRdValid or oDmRdValid, chosen by owner.
- **Read data.** oIfRdData and oDmRdData both equal iMemRdData combinationally. Only the port whose valid is high may consume the data.
- **Throughput.** One access per cycle, fully pipelined. Back-to-back grants to either port are legal.
- **Flush effect.** On an edge with iIfFlush=1, every tag entry with owner=IF has its valid bit cleared. DM entries are untouched.
- **Write/read ordering.** A DM write followed by a DM read to the same address is ordered by memory issue order. The arbiter does no extra ordering.

## Timing
- **Reset values.** All outputs are 0, all tag entries are invalid, and rLastGnt=DM, so IF wins the first tie.
- **Asynchronous reset mid-read.** Pending responses are discarded. No rd_valid is asserted after reset deasserts until a new read is granted.
- **Grant latency.** 0 cycles: gnt appears in the same cycle as req when the port wins.
- **Read latency.** Grant at edge T makes rd_valid high for exactly one cycle, in the cycle after edge T+RD_LAT-1 (that is, RD_LAT cycles after the grant cycle).
- **Write latency.** A write completes at its grant edge and produces no response.
- **Worst-case wait.** With both ports requesting continuously, grants alternate IF, DM, IF, DM and so on. No port waits more than 1 cycle.
- **Flush and IF grant in the same cycle.** The IF grant is suppressed (oIfGnt=0). DM may be granted in that cycle.
- **Simultaneous flush and tail output.** If the tail entry is IF-owned at the flush edge, its oIfRdValid is already visible in that cycle and is still asserted. Only entries that shift on or after the flush edge are killed.

## Test plan
- **Reset.** Drive resetn=0 with iIfReq=iDmReq=1. Then all outputs=0. Release reset: oIfGnt=1 and oDmGnt=0 in the first cycle, with oMemAddr=iIfAddr.
- **Single IF read** (RD_LAT=2, memory preloaded [0x10]=0xDEADBEEF). IF requests 0x10 at cycle 0. Required response: oIfGnt=1 in cycle 0, and in cycle 2 oIfRdValid=1 with oIfRdData=0xDEADBEEF. oDmRdValid stays 0 throughout.
- **Contention.** Both ports hold req for 6 cycles. Grants alternate IF, DM, IF, DM, IF, DM. Each read's valid returns to the correct port 2 cycles after its grant, and the data matches the preload.
- **DM write then read.** Write 0x1234 to address 0x40, then read 0x40. Required response: oMemWr=1 for exactly 1 cycle, and oDmRdValid returns 0x1234 two cycles after the read grant.
- **Flush.** Grant IF reads in cycles 0 and 1, then set iIfFlush=1 in cycle 2 with iIfReq=1. Required response: cycle 0's valid is seen in cycle 2, cycle 1's valid is suppressed, and oIfGnt=0 in cycle 2.
- **Reset mid-read.** Grant a DM read, then pulse resetn low 1 cycle later. Required response: no oDmRdValid at any point afterwards.
